hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, meaning the maximum number of cycles waited for dmem_ready before flagging an error (range 1..65535).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs  in  5  rs field of the ID-stage instruction.
- id_rt  in  5  rt field of the ID-stage instruction.
- id_opcode  in  6  opcode of the ID-stage instruction.
- ex_memread  in  1  MemRead of the EX-stage instruction.
- ex_rt  in  5  destination rt of the EX-stage load.
- mem_branch_taken  in  1  branch & zero, resolved in the MEM stage.
- dmem_req  in  1  MEM-stage MemRead|MemWrite.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_bubble  out  1  zero all ID/EX control bits.
- exmem_flush  out  1  zero all EX/MEM control bits.
- pipe_freeze  out  1  hold the ID/EX, EX/MEM and MEM/WB registers.
- mem_err  out  1  sticky memory-timeout flag.

Function
REQ-003 SHALL implement FSM states RUN, MEMWAIT and ERR, encoded 2 bits, registered on the rising edge of clk.
REQ-004 SHALL treat rt as an ID source only for opcodes 000000, 101011 and 000100; rs SHALL always be treated as a source.
REQ-005 SHALL detect load-use when ex_memread=1, ex_rt!=0, and ex_rt equals any ID source register.
REQ-006 In RUN with a load-use hazard and no higher-priority event, SHALL drive pc_en=0, ifid_en=0 and idex_bubble=1 for exactly that cycle, with no state change.
REQ-007 In RUN with mem_branch_taken=1, SHALL drive ifid_flush=1, idex_bubble=1 and exmem_flush=1, with pc_en=1; a branch SHALL override a load-use hazard in the same cycle.
REQ-008 In RUN with dmem_req=1 and dmem_ready=0, SHALL go to MEMWAIT next cycle and drive pc_en=0, ifid_en=0 and pipe_freeze=1 combinationally in the current cycle.
REQ-009 In RUN with dmem_req=1 and dmem_ready=1, SHALL complete the access with zero stall cycles.
REQ-010 In MEMWAIT, SHALL hold pc_en=0, ifid_en=0 and pipe_freeze=1, and suppress all flush and bubble outputs.
REQ-011 In MEMWAIT, SHALL return to RUN in the cycle after dmem_ready=1; branch and load-use evaluation SHALL resume in RUN.
REQ-012 Priority SHALL be memory wait > branch flush > load-use.
REQ-013 SHALL keep a 16-bit wait counter that clears on entry to MEMWAIT and increments each MEMWAIT cycle; when it reaches MEM_TIMEOUT without dmem_ready, the FSM SHALL go to ERR.
REQ-014 In ERR, SHALL hold mem_err=1, pc_en=0, ifid_en=0 and pipe_freeze=1 until reset.
REQ-015 Outside stall, flush and ERR conditions, outputs SHALL idle at pc_en=1 and ifid_en=1, with all other outputs 0.

Reset
REQ-016 Asserting rst_n=0 SHALL asynchronously force state RUN, wait counter 0 and mem_err 0, including during MEMWAIT or ERR.
REQ-017 While rst_n=0, SHALL drive pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1, exmem_flush=1 and pipe_freeze=0.

Configuration
REQ-018 Macro HAZARD_PERF_EN, when defined, SHALL add outputs stall_cnt[15:0] and flush_cnt[15:0], both reset to 0.
- stall_cnt increments on each cycle with pc_en=0 (outside reset) and saturates at FFFF.
- flush_cnt increments on each branch flush and saturates at FFFF.
REQ-019 Without HAZARD_PERF_EN, SHALL omit these ports and counters, with all other behaviour identical.

Structure
REQ-020 A shared package SHALL hold:
- the opcode constants OP_RTYPE=000000, OP_LW=100011, OP_SW=101011 and OP_BEQ=000100, shared with the main decoder;
- the FSM state encodings.
REQ-021 Sub-module hazard_ctrl_wait_timer SHALL hold the wait counter and timeout compare; the FSM and output logic SHALL remain in hazard_ctrl.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Load-use: ex_memread=1, ex_rt=8, id_rs=8 -> one cycle of pc_en=0 and idex_bubble=1, then idle.
- Register 0: ex_rt=0, id_rs=0, ex_memread=1 -> no stall.
- SW rt match: id_opcode=101011, id_rt=9, ex_rt=9 -> stall.
- Branch with load-use in the same cycle: mem_branch_taken=1 -> ifid_flush, idex_bubble and exmem_flush all 1, pc_en=1.
- Memory wait: dmem_req=1 with dmem_ready low for 3 cycles -> pipe_freeze=1 for 4 cycles, then RUN.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> ERR and mem_err=1; rst_n pulsed low mid-ERR -> RUN, mem_err=0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared constants for the pipeline hazard controller: instruction opcodes
//   (also used by the main decoder) and the hazard FSM state encodings.
//   Helper rt_is_src() tells whether an opcode reads rt as a source operand.
package hazard_ctrl_pkg;

    // Opcodes shared with the main decoder
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // Hazard FSM state encodings (2 bits)
    localparam logic [1:0] ST_RUN     = 2'b00;
    localparam logic [1:0] ST_MEMWAIT = 2'b01;
    localparam logic [1:0] ST_ERR     = 2'b10;

    // rt is read as a source only by R-type, SW (store data) and BEQ.
    // LW and the immediate forms write rt, so it must not raise a hazard.
    function automatic logic rt_is_src(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    endfunction

endpackage

// File: rtl/hazard_ctrl_wait_timer.sv
// hazard_ctrl_wait_timer
//   16-bit memory-wait counter with timeout compare.
//   Ports:
//     clk, rst_n  - clock, async active-low reset
//     clear       - entering MEMWAIT this cycle; counter restarts at 0
//     inc         - currently in MEMWAIT; count one more wait cycle
//     expired     - this MEMWAIT cycle is the MEM_TIMEOUT-th one
//   Parameter MEM_TIMEOUT (1..65535): wait cycles tolerated before error.
module hazard_ctrl_wait_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    // During the k-th MEMWAIT cycle (k from 0) cnt holds k, so comparing
    // against MEM_TIMEOUT-1 flags the cycle in which the count reaches
    // MEM_TIMEOUT.
    localparam logic [15:0] LIMIT = 16'(MEM_TIMEOUT - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 16'd0;
        end else if (clear) begin
            cnt <= 16'd0;
        end else if (inc && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign expired = inc && (cnt == LIMIT);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller: load-use stall, MEM-stage branch flush,
//   data-memory wait freeze and sticky memory-timeout error.
//   Priority: memory wait > branch flush > load-use.
//   Ports:
//     clk, rst_n            - clock, async active-low reset
//     id_rs, id_rt, id_opcode - ID-stage instruction fields
//     ex_memread, ex_rt     - EX-stage load and its destination
//     mem_branch_taken      - branch resolved taken in MEM
//     dmem_req, dmem_ready  - MEM-stage access handshake
//     pc_en, ifid_en        - PC / IF-ID write enables
//     ifid_flush, idex_bubble, exmem_flush - squash controls
//     pipe_freeze           - hold ID/EX, EX/MEM, MEM/WB
//     mem_err               - sticky memory-timeout flag
//   Optional (macro HAZARD_PERF_EN): stall_cnt, flush_cnt saturating
//   16-bit performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [5:0] id_opcode,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       mem_branch_taken,
    input  logic       dmem_req,
    input  logic       dmem_ready,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       exmem_flush,
    output logic       pipe_freeze,
    output logic       mem_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    logic [1:0] state;
    logic [1:0] state_next;
    logic       load_use;
    logic       mem_miss;
    logic       br_flush;
    logic       timer_clear;
    logic       timer_inc;
    logic       timer_expired;

    // Register 0 is hardwired, so a load into it never creates a hazard.
    assign load_use = ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) ||
                       (rt_is_src(id_opcode) && (ex_rt == id_rt)));

    assign mem_miss = dmem_req && !dmem_ready;

    hazard_ctrl_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .inc     (timer_inc),
        .expired (timer_expired)
    );

    always_comb begin
        state_next  = state;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        pipe_freeze = 1'b0;
        br_flush    = 1'b0;
        timer_clear = 1'b0;
        timer_inc   = 1'b0;

        case (state)
            ST_RUN: begin
                if (mem_miss) begin
                    // Freeze in the missing cycle itself, not only from MEMWAIT on.
                    state_next  = ST_MEMWAIT;
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    pipe_freeze = 1'b1;
                    timer_clear = 1'b1;
                end else if (mem_branch_taken) begin
                    // The fetch path is redirected, so the PC keeps moving.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    exmem_flush = 1'b1;
                    br_flush    = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            ST_MEMWAIT: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                pipe_freeze = 1'b1;
                timer_inc   = 1'b1;
                if (dmem_ready) begin
                    state_next = ST_RUN;
                end else if (timer_expired) begin
                    state_next = ST_ERR;
                end
            end
            ST_ERR: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                pipe_freeze = 1'b1;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase

        // While in reset the pipeline is squashed to NOPs and nothing advances.
        if (!rst_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            pipe_freeze = 1'b0;
            br_flush    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            mem_err <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next == ST_ERR) begin
                mem_err <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (!pc_en && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (br_flush && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4).
//   Observed outputs are packed as
//   {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_flush, pipe_freeze, mem_err}.
module tb_hazard_ctrl;

    localparam logic [6:0] O_IDLE   = 7'b1100000;
    localparam logic [6:0] O_RESET  = 7'b0011100;
    localparam logic [6:0] O_LDUSE  = 7'b0001000;
    localparam logic [6:0] O_BRANCH = 7'b1111100;
    localparam logic [6:0] O_FREEZE = 7'b0000010;
    localparam logic [6:0] O_ERR    = 7'b0000011;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic [5:0] id_opcode;
    logic       ex_memread, mem_branch_taken, dmem_req, dmem_ready;
    logic       pc_en, ifid_en, ifid_flush, idex_bubble, exmem_flush, pipe_freeze, mem_err;
`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif
    logic [6:0] obs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_opcode        (id_opcode),
        .ex_memread       (ex_memread),
        .ex_rt            (ex_rt),
        .mem_branch_taken (mem_branch_taken),
        .dmem_req         (dmem_req),
        .dmem_ready       (dmem_ready),
        .pc_en            (pc_en),
        .ifid_en          (ifid_en),
        .ifid_flush       (ifid_flush),
        .idex_bubble      (idex_bubble),
        .exmem_flush      (exmem_flush),
        .pipe_freeze      (pipe_freeze),
        .mem_err          (mem_err)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
`endif
    );

    assign obs = {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_flush, pipe_freeze, mem_err};

    // Advance one clock; inputs are then changed just after the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        id_rs = 5'd1; id_rt = 5'd2; id_opcode = 6'b100011;
        ex_memread = 1'b0; ex_rt = 5'd0; mem_branch_taken = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        checks++;
        if (obs !== O_RESET) begin
            errors++;
            $display("FAIL reset_outputs got %b want %b", obs, O_RESET);
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_perf got %h/%h want 0/0", stall_cnt, flush_cnt);
        end
`endif
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL idle_after_reset got %b want %b", obs, O_IDLE);
        end
        step();
    endtask

    task automatic test_load_use();
        // LW in EX writes r8, ID reads r8 through rs
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_rt = 5'd3; id_opcode = 6'b100011;
        #1;
        checks++;
        if (obs !== O_LDUSE) begin
            errors++;
            $display("FAIL load_use_rs got %b want %b", obs, O_LDUSE);
        end
        step();
        // the bubble removes the load from EX; no lingering stall
        ex_memread = 1'b0;
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL load_use_release got %b want %b", obs, O_IDLE);
        end
        step();
        // register 0 never hazards
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL load_use_r0 got %b want %b", obs, O_IDLE);
        end
        step();
        // LW in ID: rt is a destination, not a source
        ex_rt = 5'd8; id_rs = 5'd1; id_rt = 5'd8; id_opcode = 6'b100011;
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL load_use_lw_rt got %b want %b", obs, O_IDLE);
        end
        step();
        // SW reads rt
        ex_rt = 5'd9; id_rs = 5'd2; id_rt = 5'd9; id_opcode = 6'b101011;
        #1;
        checks++;
        if (obs !== O_LDUSE) begin
            errors++;
            $display("FAIL load_use_sw_rt got %b want %b", obs, O_LDUSE);
        end
        step();
        // BEQ reads rt
        id_opcode = 6'b000100;
        #1;
        checks++;
        if (obs !== O_LDUSE) begin
            errors++;
            $display("FAIL load_use_beq_rt got %b want %b", obs, O_LDUSE);
        end
        step();
        // R-type reads rt
        id_opcode = 6'b000000;
        #1;
        checks++;
        if (obs !== O_LDUSE) begin
            errors++;
            $display("FAIL load_use_rtype_rt got %b want %b", obs, O_LDUSE);
        end
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_branch();
        // branch together with a load-use hazard: branch wins
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; mem_branch_taken = 1'b1;
        #1;
        checks++;
        if (obs !== O_BRANCH) begin
            errors++;
            $display("FAIL branch_over_load_use got %b want %b", obs, O_BRANCH);
        end
        step();
        ex_memread = 1'b0;
        #1;
        checks++;
        if (obs !== O_BRANCH) begin
            errors++;
            $display("FAIL branch_alone got %b want %b", obs, O_BRANCH);
        end
        step();
        clear_inputs();
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL branch_release got %b want %b", obs, O_IDLE);
        end
        step();
    endtask

    task automatic test_mem_wait();
        // zero-stall hit
        dmem_req = 1'b1; dmem_ready = 1'b1;
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL mem_hit got %b want %b", obs, O_IDLE);
        end
        step();
        // miss with a taken branch in the same cycle: memory wait wins
        dmem_ready = 1'b0; mem_branch_taken = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                mem_branch_taken = 1'b1;
                ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
            end
            if (c == 3) dmem_ready = 1'b1;
            #1;
            checks++;
            if (obs !== O_FREEZE) begin
                errors++;
                $display("FAIL mem_wait_cycle%0d got %b want %b", c, obs, O_FREEZE);
            end
            step();
            mem_branch_taken = 1'b0;
        end
        // back in RUN: load-use evaluation resumes
        dmem_req = 1'b0; dmem_ready = 1'b0;
        #1;
        checks++;
        if (obs !== O_LDUSE) begin
            errors++;
            $display("FAIL mem_wait_resume got %b want %b", obs, O_LDUSE);
        end
        step();
        clear_inputs();
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL mem_wait_idle got %b want %b", obs, O_IDLE);
        end
        step();
    endtask

    task automatic test_timeout();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        step();
        step();
        // two MEMWAIT cycles in: still waiting, no error yet
        #1;
        checks++;
        if (obs !== O_FREEZE) begin
            errors++;
            $display("FAIL timeout_early got %b want %b", obs, O_FREEZE);
        end
        for (int c = 0; c < 6; c++) step();
        #1;
        checks++;
        if (obs !== O_ERR) begin
            errors++;
            $display("FAIL timeout_err got %b want %b", obs, O_ERR);
        end
        // ERR is sticky even if memory answers late
        dmem_ready = 1'b1; dmem_req = 1'b0;
        step();
        #1;
        checks++;
        if (obs !== O_ERR) begin
            errors++;
            $display("FAIL err_sticky got %b want %b", obs, O_ERR);
        end
        // async reset mid-cycle
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== O_RESET) begin
            errors++;
            $display("FAIL err_async_reset got %b want %b", obs, O_RESET);
        end
        step();
        rst_n = 1'b1;
        clear_inputs();
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL err_after_reset got %b want %b", obs, O_IDLE);
        end
        step();
        // a fresh miss is a normal wait again (state really back in RUN)
        dmem_req = 1'b1;
        step();
        dmem_ready = 1'b1;
        step();
        dmem_req = 1'b0; dmem_ready = 1'b0;
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL wait_after_reset got %b want %b", obs, O_IDLE);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
